host_mem_bridge: RTL and testbench
==================================

# host_mem_bridge

Host-side front end for the shared byte-addressed synchronous memory. It converts burst read/write requests from the host transport into per-beat traffic on the memory's host write port (`hw_*`) and host read port (`hr_*`). It absorbs the memory's one-cycle registered-address read latency and buffers read data so the host can apply backpressure. It sits directly upstream of the memory and is its only driver on the host ports.

## Interface
- `ADDR_WIDTH`, 21: byte-address width; matches the memory.
- `DATA_WIDTH`, 32: beat width; multiple of 8. `MASK_WIDTH = DATA_WIDTH/8`.
- `LEN_WIDTH`, 4: burst-length field width; a burst is `req_len+1` beats, 1..16.

- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` / `req_ready` in/out 1: request handshake.
- `req_write` in 1: 1 = write burst, 0 = read burst.
- `req_addr` in ADDR_WIDTH: first byte address.
- `req_len` in LEN_WIDTH: beats minus one.
- `wdata_valid` / `wdata_ready` in/out 1: write-data handshake.
- `wdata` in DATA_WIDTH: write beat.
- `wmask` in MASK_WIDTH: byte enables for the write beat.
- `resp_valid` / `resp_ready` out/in 1: response handshake.
- `resp_data` out DATA_WIDTH: read beat; 0 for write acks.
- `resp_last` out 1: final response beat of a burst.
- `resp_err` out 1: error flag (see Configuration).
- `hw_addr`, `hw_data`, `hw_mask`, `hw_en` out: memory write port, all registered.
- `hr_addr` out ADDR_WIDTH: memory read address.
- `hr_data` in DATA_WIDTH: memory read data; valid the cycle after `hr_addr`.

## Operation
- FSM states: IDLE, WRITE, WACK, READ.
- `req_ready = (state==IDLE)`. Requests are accepted only in IDLE; one burst is outstanding at a time.
- On request accept: latch the address into an address counter, latch `req_len` into a beat counter, then go to WRITE or READ.
- **WRITE**
  - `wdata_ready = 1`.
  - Each handshake registers `hw_en=1`, `hw_addr`, `hw_data` and `hw_mask` for the next cycle.
  - Address counter advances by `MASK_WIDTH`, modulo 2^ADDR_WIDTH (wrap-around is permitted).
  - After the last beat, go to WACK.
- **WACK**
  - `resp_valid=1`, `resp_last=1`, `resp_data=0`.
  - On `resp_ready`, go to IDLE.
- **READ**
  - A beat is issued when beats remain and `fifo_count + inflight - pop < 2`.
  - Issuing drives `hr_addr` with the counter value and sets the `inflight` flag.
  - In the next cycle `hr_data` is pushed into a 2-entry response FIFO. `resp_last` is tagged on the final beat.
  - Leave READ for IDLE when the last beat pops.
- When not issuing a read, `hr_addr` holds its last value.
- `hw_en` is 0 in every cycle without a write handshake.
- Reset mid-burst: FSM returns to IDLE, the FIFO empties, `inflight` clears, and partial bursts are dropped with no response. Writes already registered on `hw_*` during the reset cycle are suppressed (`hw_en` forced to 0).
- `wdata_valid` outside WRITE is ignored, with `wdata_ready=0`.

## Timing
- Reset values: `req_ready=1`. `wdata_ready`, `resp_valid`, `resp_last`, `resp_err`, `hw_en` are 0. `hw_addr`, `hw_data`, `hw_mask`, `hr_addr`, `resp_data` are 0.
- Write: beat handshake at edge k puts `hw_en=1` in cycle k+1, and memory is updated at edge k+1. The ack is valid the cycle after the last-beat handshake.
- Read: request accepted at edge k; `hr_addr` is set during cycle k+1, `hr_data` arrives in cycle k+2, and `resp_valid` rises in cycle k+3.
- With `resp_ready` held at 1, reads sustain 1 beat/cycle.
- Full FIFO stalls issue. A pop in the same cycle frees a slot in that cycle.
- A read request accepted after a WACK handshake always observes the completed write.

## Configuration
- `HOST_BRIDGE_ALIGN_CHECK_EN` defined:
  - A request whose `req_addr` is not `MASK_WIDTH`-aligned is accepted but never touches memory.
  - A write still consumes all of its wdata beats, with `hw_en` held at 0.
  - Then a single response with `resp_err=1`, `resp_last=1` and `resp_data=0` is returned.
- `HOST_BRIDGE_ALIGN_CHECK_EN` undefined: addresses pass through unchecked and `resp_err` is tied to 0.

## Structure
- `host_bridge_pkg` holds:
  - the state enum `hb_state_e`;
  - `FIFO_DEPTH = 2`;
  - a helper function for the per-beat address increment.
- One sub-module, `hb_resp_fifo`: 2-entry FIFO of `{last, err, data}` with push, pop, count, and synchronous reset.

## Test plan
- Single write, addr 0x100, data 0xDEADBEEF, mask 0xF:
  - `hw_en` pulses for exactly one cycle with those values;
  - ack `resp_last=1`;
  - a following read of 0x100 returns 0xDEADBEEF.
- 4-beat read at 0x200 with `resp_ready=1`:
  - `resp_valid` first rises 3 cycles after accept;
  - 4 consecutive beats follow, `resp_last` on the 4th;
  - `hr_addr` steps 0x200, 0x204, 0x208, 0x20C.
- 16-beat read with `resp_ready` toggled every other cycle: no beat is lost or duplicated, and the FIFO never exceeds 2 entries.
- Write burst at 0x1FFFFC, len 1: the second beat wraps to `hw_addr` 0x000000.
- Partial mask 0x5 with data 0x11223344 over a background of 0xFFFFFFFF: readback is 0xFF22FF44.
- Reset asserted mid-way through an 8-beat read:
  - the next cycle shows `resp_valid=0` and `req_ready=1`;
  - a new request completes normally.
- With `HOST_BRIDGE_ALIGN_CHECK_EN` defined, read at 0x102: a single response with `resp_err=1`.

Source files
------------

// File: rtl/host_bridge_pkg.sv
// host_bridge_pkg: shared types for host_mem_bridge.
// FSM states, response FIFO depth, per-beat address step.
package host_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    WACK,
    READ
  } hb_state_e;

  localparam int FIFO_DEPTH = 2;

  // Next beat address; caller truncates to its width (wraps).
  function automatic logic [31:0] hb_next_addr(
    input logic [31:0] addr,
    input logic [31:0] step
  );
    return addr + step;
  endfunction

endpackage

// File: rtl/hb_resp_fifo.sv
// hb_resp_fifo: 2-entry response buffer of {last, err, data}.
// Head is always visible; push and pop may share a cycle.
module hb_resp_fifo
  import host_bridge_pkg::*;
#(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [FIFO_DEPTH];
  logic [W-1:0] mem_d [FIFO_DEPTH];
  logic         wp_q, wp_d;
  logic         rp_q, rp_d;
  logic [1:0]   cnt_q, cnt_d;

  // Next pointers, occupancy and storage.
  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    if (push) begin
      mem_d[wp_q] = push_data;
      wp_d        = ~wp_q;
    end
    if (pop) begin
      rp_d = ~rp_q;
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  // Register state; reset empties the buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[rp_q];
  assign count = cnt_q;

endmodule

// File: rtl/host_mem_bridge.sv
// host_mem_bridge: burst host requests to per-beat memory traffic.
// Optional HOST_BRIDGE_ALIGN_CHECK_EN: misaligned bursts answer resp_err.
module host_mem_bridge
  import host_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4,
  localparam int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [MASK_WIDTH-1:0] wmask,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_last,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] hw_addr,
  output logic [DATA_WIDTH-1:0] hw_data,
  output logic [MASK_WIDTH-1:0] hw_mask,
  output logic                  hw_en,
  output logic [ADDR_WIDTH-1:0] hr_addr,
  input  logic [DATA_WIDTH-1:0] hr_data
);

  localparam int FW = DATA_WIDTH + 2;

  hb_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  beats_q, beats_d;
  logic [LEN_WIDTH:0]    issue_q, issue_d;
  logic                  inflight_q, inflight_d;
  logic                  infl_last_q, infl_last_d;
  logic                  err_q, err_d;
  logic                  hw_en_q, hw_en_d;
  logic [ADDR_WIDTH-1:0] hw_addr_q, hw_addr_d;
  logic [DATA_WIDTH-1:0] hw_data_q, hw_data_d;
  logic [MASK_WIDTH-1:0] hw_mask_q, hw_mask_d;
  logic [ADDR_WIDTH-1:0] hr_hold_q, hr_hold_d;

  logic                  acc, wr_hs, pop, issue, misalign;
  logic [1:0]            fifo_count;
  logic [2:0]            occ;
  logic [FW-1:0]         head;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic [ADDR_WIDTH-1:0] lsb_mask;

  assign lsb_mask = ADDR_WIDTH'(MASK_WIDTH - 1);

`ifdef HOST_BRIDGE_ALIGN_CHECK_EN
  assign misalign = |(req_addr & lsb_mask);
`else
  assign misalign = 1'b0;
`endif

  assign addr_inc = ADDR_WIDTH'(hb_next_addr(32'(addr_q),
                                             32'(MASK_WIDTH)));

  assign acc   = req_valid && (state_q == IDLE);
  assign wr_hs = wdata_valid && (state_q == WRITE);
  assign pop   = (state_q == READ) && (fifo_count != 2'd0)
                 && resp_ready;
  assign occ   = {1'b0, fifo_count} + {2'b0, inflight_q};
  // A pop this cycle frees a slot for the issue this cycle.
  assign issue = (state_q == READ) && !reset
                 && (issue_q != '0)
                 && (occ < (3'd2 + {2'b0, pop}));

  hb_resp_fifo #(
    .W(FW)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (inflight_q),
    .push_data({infl_last_q, err_q, hr_data}),
    .pop      (pop),
    .head     (head),
    .count    (fifo_count)
  );

  // FSM next state, beat counters and write-port capture.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    beats_d   = beats_q;
    issue_d   = issue_q;
    err_d     = err_q;
    hw_en_d   = 1'b0;
    hw_addr_d = hw_addr_q;
    hw_data_d = hw_data_q;
    hw_mask_d = hw_mask_q;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          addr_d  = req_addr;
          beats_d = req_len;
          issue_d = {1'b0, req_len} + (LEN_WIDTH+1)'(1);
          err_d   = misalign;
          if (req_write) begin
            state_d = WRITE;
          end else if (misalign) begin
            state_d = WACK;
          end else begin
            state_d = READ;
          end
        end
      end
      WRITE: begin
        if (wr_hs) begin
          hw_en_d = !err_q;
          if (!err_q) begin
            hw_addr_d = addr_q;
            hw_data_d = wdata;
            hw_mask_d = wmask;
          end
          addr_d  = addr_inc;
          beats_d = beats_q - LEN_WIDTH'(1);
          if (beats_q == '0) begin
            state_d = WACK;
          end
        end
      end
      WACK: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (issue) begin
          addr_d  = addr_inc;
          issue_d = issue_q - (LEN_WIDTH+1)'(1);
        end
        if (pop && head[FW-1]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    inflight_d  = issue;
    infl_last_d = issue && (issue_q == (LEN_WIDTH+1)'(1));
    hr_hold_d   = issue ? addr_q : hr_hold_q;
  end

  // State and registered outputs; reset drops any partial burst.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      beats_q     <= '0;
      issue_q     <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      err_q       <= 1'b0;
      hw_en_q     <= 1'b0;
      hw_addr_q   <= '0;
      hw_data_q   <= '0;
      hw_mask_q   <= '0;
      hr_hold_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      beats_q     <= beats_d;
      issue_q     <= issue_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      err_q       <= err_d;
      hw_en_q     <= hw_en_d;
      hw_addr_q   <= hw_addr_d;
      hw_data_q   <= hw_data_d;
      hw_mask_q   <= hw_mask_d;
      hr_hold_q   <= hr_hold_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign wdata_ready = (state_q == WRITE);
  assign resp_valid  = (state_q == WACK)
                       || ((state_q == READ) && (fifo_count != 2'd0));
  assign resp_last   = (state_q == WACK)
                       || ((state_q == READ) && (fifo_count != 2'd0)
                           && head[FW-1]);
  assign resp_err    = ((state_q == WACK) && err_q)
                       || ((state_q == READ) && (fifo_count != 2'd0)
                           && head[FW-2]);
  assign resp_data   = (state_q == READ) ? head[DATA_WIDTH-1:0] : '0;
  assign hr_addr     = issue ? addr_q : hr_hold_q;
  assign hw_en       = hw_en_q && !reset;
  assign hw_addr     = hw_addr_q;
  assign hw_data     = hw_data_q;
  assign hw_mask     = hw_mask_q;

endmodule

// File: tb/tb_host_mem_bridge.sv
// tb_host_mem_bridge: directed bench for host_mem_bridge.
// Owns a byte memory model with registered-address reads.
module tb_host_mem_bridge;

  localparam int AW = 21;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic          wdata_valid, wdata_ready;
  logic [DW-1:0] wdata;
  logic [MW-1:0] wmask;
  logic          resp_valid, resp_ready, resp_last, resp_err;
  logic [DW-1:0] resp_data;
  logic [AW-1:0] hw_addr, hr_addr;
  logic [DW-1:0] hw_data, hr_data;
  logic [MW-1:0] hw_mask;
  logic          hw_en;

  host_mem_bridge #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .wdata_valid(wdata_valid),
    .wdata_ready(wdata_ready),
    .wdata      (wdata),
    .wmask      (wmask),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_last  (resp_last),
    .resp_err   (resp_err),
    .hw_addr    (hw_addr),
    .hw_data    (hw_data),
    .hw_mask    (hw_mask),
    .hw_en      (hw_en),
    .hr_addr    (hr_addr),
    .hr_data    (hr_data)
  );

  always #5 clk = ~clk;

  logic [7:0]    mem [0:(1<<AW)-1];
  logic [DW-1:0] hr_q;
  assign hr_data = hr_q;

  always @(posedge clk) begin
    if (hw_en) begin
      for (int i = 0; i < MW; i++) begin
        if (hw_mask[i]) mem[AW'(hw_addr + AW'(i))] <= hw_data[8*i +: 8];
      end
    end
    for (int i = 0; i < MW; i++) begin
      hr_q[8*i +: 8] <= mem[AW'(hr_addr + AW'(i))];
    end
  end

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [MW-1:0] m;
  } hw_t;

  hw_t hw_log [$];
  int  maxc;

  always @(negedge clk) begin
    if (hw_en) hw_log.push_back('{a: hw_addr, d: hw_data, m: hw_mask});
    if (int'(dut.fifo_count) > maxc) maxc = int'(dut.fifo_count);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] wd [16];
  logic [MW-1:0] wm [16];
  logic [DW-1:0] rdat [32];
  logic          rlast [32];
  logic [AW-1:0] hra [100];
  logic          rerr;
  int            got_n, first_c, last_c;
  bit            ack_seen;
  int            ack_wait;
  logic          ack_last, ack_err;
  logic [DW-1:0] ack_data;

  task automatic put_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    for (int i = 0; i < MW; i++) mem[AW'(a + AW'(i))] = d[8*i +: 8];
  endtask

  task automatic accept_req(input bit w, input logic [AW-1:0] a,
                            input int n);
    bit acc = 0;
    req_valid = 1; req_write = w; req_addr = a; req_len = LW'(n - 1);
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clk); acc = req_ready;
      @(posedge clk); #1;
    end
    req_valid = 0; req_write = 0;
    chk("req_accept", acc, 1);
  endtask

  task automatic wr_burst(input logic [AW-1:0] a, input int n);
    bit ok;
    int t;
    hw_log.delete();
    resp_ready = 1;
    accept_req(1, a, n);
    for (int i = 0; i < n; i++) begin
      wdata_valid = 1; wdata = wd[i]; wmask = wm[i]; ok = 0;
      for (int k = 0; k < 20 && !ok; k++) begin
        @(negedge clk); ok = wdata_ready;
        @(posedge clk); #1;
      end
      chk("wbeat_ready", ok, 1);
    end
    wdata_valid = 0;
    ack_seen = 0; ack_wait = -1; t = 0;
    while (!ack_seen && t < 20) begin
      @(negedge clk);
      if (resp_valid) begin
        ack_seen = 1; ack_wait = t; ack_last = resp_last;
        ack_data = resp_data; ack_err = resp_err;
      end
      @(posedge clk); #1;
      t++;
    end
    chk("wr_ack_seen", ack_seen, 1);
  endtask

  task automatic rd_burst(input logic [AW-1:0] a, input int n,
                          input bit tog);
    bit done = 0;
    int c = 0;
    got_n = 0; first_c = -1; last_c = -1; rerr = 0;
    resp_ready = 1;
    accept_req(0, a, n);
    while (!done && c < 80) begin
      c++;
      if (tog) resp_ready = c[0];
      @(negedge clk);
      hra[c] = hr_addr;
      if (resp_valid && first_c < 0) first_c = c;
      if (resp_valid && resp_ready) begin
        if (got_n < 32) begin
          rdat[got_n] = resp_data; rlast[got_n] = resp_last;
        end
        rerr |= resp_err;
        got_n++;
        if (resp_last) begin done = 1; last_c = c; end
      end
      @(posedge clk); #1;
    end
    resp_ready = 1;
    chk("rd_done", done, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    hw_t e;
    int nb, nl;
    logic [3:0] lp;
    reset = 1; req_valid = 0; req_write = 0; req_addr = '0; req_len = '0;
    wdata_valid = 0; wdata = '0; wmask = '0; resp_ready = 0; maxc = 0;
    for (int i = 0; i < 4; i++)  put_word(AW'(32'h200 + 4*i), 32'hA000_0000 + i);
    for (int i = 0; i < 16; i++) put_word(AW'(32'h400 + 4*i), 32'h1000_0000 + i);
    for (int i = 0; i < 8; i++)  put_word(AW'(32'h500 + 4*i), 32'h5500_0000 + i);
    put_word(21'h600, 32'h0BAD_F00D);
    repeat (3) @(posedge clk);
    #1 reset = 0;

    chk("rst_req_ready", req_ready, 1);
    chk("rst_wdata_ready", wdata_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_last", resp_last, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_hw_en", hw_en, 0);
    chk("rst_hw_addr", hw_addr, 0);
    chk("rst_hw_data", hw_data, 0);
    chk("rst_hw_mask", hw_mask, 0);
    chk("rst_hr_addr", hr_addr, 0);

    wd[0] = 32'hDEAD_BEEF; wm[0] = 4'hF;
    wr_burst(21'h100, 1);
    chk("w1_pulses", hw_log.size(), 1);
    e = (hw_log.size() > 0) ? hw_log[0] : '0;
    chk("w1_hw_addr", e.a, 21'h100);
    chk("w1_hw_data", e.d, 32'hDEAD_BEEF);
    chk("w1_hw_mask", e.m, 4'hF);
    chk("w1_ack_wait", ack_wait, 0);
    chk("w1_ack_last", ack_last, 1);
    chk("w1_ack_data", ack_data, 0);
    chk("w1_ack_err", ack_err, 0);
    rd_burst(21'h100, 1, 0);
    chk("r1_n", got_n, 1);
    chk("r1_data", rdat[0], 32'hDEAD_BEEF);

    rd_burst(21'h200, 4, 0);
    chk("r4_first", first_c, 3);
    chk("r4_lastcyc", last_c, 6);
    chk("r4_n", got_n, 4);
    nb = 0; lp = '0;
    for (int i = 0; i < 4; i++) begin
      if (rdat[i] !== 32'hA000_0000 + i) nb++;
      lp[i] = rlast[i];
    end
    chk("r4_data_bad", nb, 0);
    chk("r4_last", lp, 4'b1000);
    chk("r4_err", rerr, 0);
    chk("r4_hra0", hra[1], 21'h200);
    chk("r4_hra1", hra[2], 21'h204);
    chk("r4_hra2", hra[3], 21'h208);
    chk("r4_hra3", hra[4], 21'h20C);

    maxc = 0;
    rd_burst(21'h400, 16, 1);
    chk("r16_n", got_n, 16);
    nb = 0; nl = 0;
    for (int i = 0; i < 16; i++) begin
      if (rdat[i] !== 32'h1000_0000 + i) nb++;
      if (i < 15 && rlast[i]) nl++;
    end
    chk("r16_data_bad", nb, 0);
    chk("r16_early_last", nl, 0);
    chk("r16_last", rlast[15], 1);
    chk("r16_fifo_over2", maxc > 2, 0);

    wd[0] = 32'h0102_0304; wm[0] = 4'hF;
    wd[1] = 32'h0506_0708; wm[1] = 4'hF;
    wr_burst(21'h1F_FFFC, 2);
    chk("wrap_pulses", hw_log.size(), 2);
    e = (hw_log.size() > 0) ? hw_log[0] : '0;
    chk("wrap_addr0", e.a, 21'h1F_FFFC);
    e = (hw_log.size() > 1) ? hw_log[1] : '0;
    chk("wrap_addr1", e.a, 21'h0);
    chk("wrap_data1", e.d, 32'h0506_0708);
    rd_burst(21'h0, 1, 0);
    chk("wrap_rd", rdat[0], 32'h0506_0708);

    wd[0] = 32'hFFFF_FFFF; wm[0] = 4'hF;
    wr_burst(21'h300, 1);
    wd[0] = 32'h1122_3344; wm[0] = 4'h5;
    wr_burst(21'h300, 1);
    rd_burst(21'h300, 1, 0);
    chk("mask_rd", rdat[0], 32'hFF22_FF44);

    resp_ready = 1;
    accept_req(0, 21'h500, 8);
    repeat (4) @(posedge clk);
    #1;
    chk("rst8_mid_valid", resp_valid, 1);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("rst8_resp_valid", resp_valid, 0);
    chk("rst8_req_ready", req_ready, 1);
    rd_burst(21'h200, 2, 0);
    chk("rst8_new_n", got_n, 2);
    chk("rst8_new_d0", rdat[0], 32'hA000_0000);
    chk("rst8_new_d1", rdat[1], 32'hA000_0001);

    accept_req(1, 21'h600, 1);
    wdata_valid = 1; wdata = 32'h1234_5678; wmask = 4'hF;
    @(posedge clk); #1;
    wdata_valid = 0;
    reset = 1;
    @(negedge clk);
    chk("rstw_hw_en", hw_en, 0);
    @(posedge clk); #1;
    reset = 0;
    rd_burst(21'h600, 1, 0);
    chk("rstw_rd", rdat[0], 32'h0BAD_F00D);

`ifdef HOST_BRIDGE_ALIGN_CHECK_EN
    rd_burst(21'h102, 4, 0);
    chk("al_n", got_n, 1);
    chk("al_err", rerr, 1);
    chk("al_last", rlast[0], 1);
    chk("al_data", rdat[0], 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
